// File: rtl/fft_sink_rx.sv
// fft_sink_rx: receives FFT core source frames, produces per-bin power
// (real^2 + imag^2) through a 2-stage pipeline, tracks frame framing errors
// and core errors, and reports the block exponent and (optionally) the peak
// bin of every good frame.
// Optional feature: define FFT_PEAK_DET_EN to compile in the peak search over
// bins 1..FFT_LEN/2-1; without it peak_bin and peak_pwr are tied to 0.
module fft_sink_rx #(
  parameter int FFT_LEN = 1024,
  parameter int DW      = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         src_valid,
  output logic                         src_ready,
  input  logic                         src_sop,
  input  logic                         src_eop,
  input  logic [1:0]                   src_error,
  input  logic signed [5:0]            src_exp,
  input  logic signed [DW-1:0]         src_real,
  input  logic signed [DW-1:0]         src_imag,
  output logic                         pwr_valid,
  output logic [2*DW:0]                pwr,
  output logic [$clog2(FFT_LEN)-1:0]   pwr_bin,
  output logic                         pwr_sop,
  output logic                         pwr_eop,
  output logic                         frame_done,
  output logic [$clog2(FFT_LEN)-1:0]   peak_bin,
  output logic [2*DW:0]                peak_pwr,
  output logic signed [5:0]            frame_exp,
  output logic                         err_frame,
  output logic                         err_core,
  input  logic                         clr_err
);

  localparam int BW = $clog2(FFT_LEN);
  localparam logic [BW-1:0] BIN_ONE  = BW'(1);
  localparam logic [BW-1:0] BIN_LAST = BW'(FFT_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Full-width square: sign-extend first so -2^(DW-1) squared cannot wrap.
  function automatic logic [2*DW-1:0] f_square(input logic signed [DW-1:0] v);
    logic signed [2*DW-1:0] ext;
    logic signed [2*DW-1:0] prod;
    ext  = {{DW{v[DW-1]}}, v};
    prod = ext * ext;
    return prod;
  endfunction

  // Power sum with one carry bit of headroom; never saturates.
  function automatic logic [2*DW:0] f_pwr_sum(input logic [2*DW-1:0] a,
                                               input logic [2*DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [1:0]          r_state;
  logic [1:0]          r_state_nx;
  logic [BW-1:0]       r_cnt;
  logic [BW-1:0]       r_cnt_nx;
  logic [1:0]          r_drain;
  logic                r_err_frame;
  logic                r_err_core;

  logic                w_acc;
  logic                w_issue;
  logic [BW-1:0]       w_bin;
  logic                w_ferr;
  logic                w_last_good;
  logic                w_cap_exp;

  logic [2*DW-1:0]     r_sq_re_p1;
  logic [2*DW-1:0]     r_sq_im_p1;
  logic [BW-1:0]       r_bin_p1;
  logic                vld_p1;
  logic                r_good_p1;
  logic signed [5:0]   r_exp_pend;
  logic [2*DW:0]       w_sum;

  logic                vld_p2;
  logic [2*DW:0]       r_pwr_p2;
  logic [BW-1:0]       r_bin_p2;
  logic                r_sop_p2;
  logic                r_eop_p2;
  logic                r_good_p2;
  logic                r_done;
  logic signed [5:0]   r_fexp;

  assign src_ready = (r_state != S_DRAIN);
  assign w_acc     = src_valid & src_ready;
  assign w_sum     = f_pwr_sum(r_sq_re_p1, r_sq_im_p1);

  // Frame FSM next state, beat issue and framing-error detection.
  always_comb begin
    r_state_nx  = r_state;
    r_cnt_nx    = r_cnt;
    w_issue     = 1'b0;
    w_bin       = r_cnt;
    w_ferr      = 1'b0;
    w_last_good = 1'b0;
    w_cap_exp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (src_sop) begin
            w_issue   = 1'b1;
            w_bin     = '0;
            w_cap_exp = 1'b1;
            if (src_eop) begin
              w_ferr   = 1'b1;
              r_cnt_nx = '0;
            end else begin
              r_state_nx = S_RECV;
              r_cnt_nx   = BIN_ONE;
            end
          end else begin
            w_ferr = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (w_acc) begin
          w_issue = 1'b1;
          if (src_sop) begin
            // Restart: this beat becomes bin 0 of a fresh frame.
            w_ferr    = 1'b1;
            w_bin     = '0;
            w_cap_exp = 1'b1;
            if (src_eop) begin
              r_state_nx = S_IDLE;
              r_cnt_nx   = '0;
            end else begin
              r_cnt_nx = BIN_ONE;
            end
          end else if (r_cnt == BIN_LAST) begin
            r_cnt_nx = '0;
            if (src_eop) begin
              w_last_good = 1'b1;
              r_state_nx  = S_DRAIN;
            end else begin
              w_ferr     = 1'b1;
              r_state_nx = S_IDLE;
            end
          end else if (src_eop) begin
            w_ferr     = 1'b1;
            r_state_nx = S_IDLE;
            r_cnt_nx   = '0;
          end else begin
            r_cnt_nx = r_cnt + BIN_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain == 2'd2) r_state_nx = S_IDLE;
      end
      default: begin
        r_state_nx = S_IDLE;
        r_cnt_nx   = '0;
      end
    endcase
  end

  // Control state: FSM, bin counter, drain timer, sticky flags, stage-1 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_drain     <= 2'd0;
      r_err_frame <= 1'b0;
      r_err_core  <= 1'b0;
      vld_p1      <= 1'b0;
      r_good_p1   <= 1'b0;
    end else begin
      r_state   <= r_state_nx;
      r_cnt     <= r_cnt_nx;
      r_drain   <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
      vld_p1    <= w_issue;
      r_good_p1 <= w_last_good;
      if (w_ferr)       r_err_frame <= 1'b1;
      else if (clr_err) r_err_frame <= 1'b0;
      if (w_acc && (src_error != 2'b00)) r_err_core <= 1'b1;
      else if (clr_err)                  r_err_core <= 1'b0;
    end
  end

  // ---- stage 1: register both squares and the bin index ----
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_sq_re_p1 <= f_square(src_real);
      r_sq_im_p1 <= f_square(src_imag);
      r_bin_p1   <= w_bin;
    end
    if (w_cap_exp) r_exp_pend <= src_exp;
  end

  // ---- stage 2: register the power sum and its framing marks ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      r_pwr_p2  <= '0;
      r_bin_p2  <= '0;
      r_sop_p2  <= 1'b0;
      r_eop_p2  <= 1'b0;
      r_good_p2 <= 1'b0;
    end else begin
      vld_p2    <= vld_p1;
      r_good_p2 <= vld_p1 & r_good_p1;
      r_sop_p2  <= vld_p1 && (r_bin_p1 == '0);
      r_eop_p2  <= vld_p1 && (r_bin_p1 == BIN_LAST);
      if (vld_p1) begin
        r_pwr_p2 <= w_sum;
        r_bin_p2 <= r_bin_p1;
      end
    end
  end

  // ---- frame completion: pulse and exponent update one cycle after eop ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_fexp <= '0;
    end else begin
      r_done <= vld_p2 & r_good_p2;
      if (vld_p2 & r_good_p2) r_fexp <= r_exp_pend;
    end
  end

`ifdef FFT_PEAK_DET_EN
  localparam logic [BW-1:0] BIN_HALF = BW'(FFT_LEN / 2);

  logic [BW-1:0] r_run_bin;
  logic [2*DW:0] r_run_pwr;
  logic [BW-1:0] r_peak_bin;
  logic [2*DW:0] r_peak_pwr;

  // Running peak: bin 1 seeds the search, later lower-half bins win only when strictly greater.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      if (r_bin_p1 == BIN_ONE) begin
        r_run_bin <= r_bin_p1;
        r_run_pwr <= w_sum;
      end else if ((r_bin_p1 > BIN_ONE) && (r_bin_p1 < BIN_HALF) && (w_sum > r_run_pwr)) begin
        r_run_bin <= r_bin_p1;
        r_run_pwr <= w_sum;
      end
    end
  end

  // Publish the running peak together with frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_bin <= '0;
      r_peak_pwr <= '0;
    end else if (vld_p2 & r_good_p2) begin
      r_peak_bin <= r_run_bin;
      r_peak_pwr <= r_run_pwr;
    end
  end

  assign peak_bin = r_peak_bin;
  assign peak_pwr = r_peak_pwr;
`else
  assign peak_bin = '0;
  assign peak_pwr = '0;
`endif

  assign pwr_valid  = vld_p2;
  assign pwr        = r_pwr_p2;
  assign pwr_bin    = r_bin_p2;
  assign pwr_sop    = r_sop_p2;
  assign pwr_eop    = r_eop_p2;
  assign frame_done = r_done;
  assign frame_exp  = r_fexp;
  assign err_frame  = r_err_frame;
  assign err_core   = r_err_core;

endmodule

// File: doc/fft_sink_rx.md
FFT_SINK_RX -- requirements
Module: fft_sink_rx

Interface
REQ-001 SHALL have parameter FFT_LEN, default 1024, frame length in bins (power of two, 8 to 4096).
REQ-002 SHALL have parameter DW, default 12, signed width of src_real and src_imag.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port src_valid  input  1  FFT core source beat valid.
REQ-006 SHALL have port src_ready  output  1  block accepts a beat; a beat transfers when src_valid and src_ready are both high.
REQ-007 SHALL have port src_sop / src_eop  input  1 each  first / last beat of a frame.
REQ-008 SHALL have port src_error  input  2  core error code, nonzero means fault.
REQ-009 SHALL have port src_exp  input  6  signed block exponent of the frame.
REQ-010 SHALL have port src_real / src_imag  input  DW each  signed two's-complement bin value.
REQ-011 SHALL have port pwr_valid  output  1  pwr beat valid.
REQ-012 SHALL have port pwr  output  2*DW+1  unsigned real^2+imag^2.
REQ-013 SHALL have port pwr_bin  output  log2(FFT_LEN)  bin index of pwr.
REQ-014 SHALL have port pwr_sop / pwr_eop  output  1 each  marks bin 0 / bin FFT_LEN-1.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after each good frame.
REQ-016 SHALL have port peak_bin  output  log2(FFT_LEN)  and peak_pwr  output  2*DW+1  frame peak.
REQ-017 SHALL have port frame_exp  output  6  src_exp captured on the sop beat of the last good frame.
REQ-018 SHALL have port err_frame / err_core  output  1 each  sticky error flags.
REQ-019 SHALL have port clr_err  input  1  synchronous clear of both sticky flags.

Function
REQ-020 SHALL implement FSM IDLE, RECV, DRAIN; IDLE->RECV on accepted sop beat; RECV->DRAIN on accepted eop beat with bin count FFT_LEN-1; DRAIN->IDLE after 3 cycles.
REQ-021 SHALL drive src_ready high in IDLE and RECV, low in DRAIN.
REQ-022 SHALL count accepted beats from 0 at sop; pwr_bin carries that count.
REQ-023 SHALL compute pwr with 2-stage pipeline: stage 1 registers both squares, stage 2 registers the sum; pwr_valid follows accepted beat by exactly 2 cycles, no bubbles inserted.
REQ-024 SHALL compute squares at full 2*DW width; -2^(DW-1) squared SHALL not overflow; the sum SHALL not saturate.
REQ-025 SHALL compare pwr of bins 1..FFT_LEN/2-1 only (DC and mirror half excluded); strictly greater updates the peak, ties keep the lower bin.
REQ-026 SHALL pulse frame_done one cycle after pwr_eop, and update peak_bin, peak_pwr, frame_exp in that same cycle; the values SHALL hold until the next frame_done.
REQ-027 Accepted beat in IDLE without sop SHALL be dropped (no pwr_valid) and set err_frame.
REQ-028 Accepted sop in RECV SHALL set err_frame, discard the partial peak, and restart the frame at bin 0.
REQ-029 Accepted eop at count below FFT_LEN-1, or count FFT_LEN-1 without eop, SHALL set err_frame, return to IDLE, and suppress frame_done; pwr beats already issued SHALL complete.
REQ-030 Accepted beat with src_error nonzero SHALL set err_core; processing SHALL continue unchanged.
REQ-031 clr_err and a new error in the same cycle: the flag SHALL end set.

Reset
REQ-032 rst_n low SHALL immediately force the FSM to IDLE, the bin count to 0, and every output to 0 except src_ready, which SHALL be 1 after reset.
REQ-033 Reset mid-frame SHALL discard the frame and pipeline contents; no frame_done SHALL follow.

Configuration
REQ-034 Macro FFT_PEAK_DET_EN defined: the peak search of REQ-025 SHALL be compiled in.
REQ-035 Macro FFT_PEAK_DET_EN undefined: peak_bin and peak_pwr SHALL be constant 0; all other behaviour SHALL be identical, including frame_done and frame_exp.

Verification
REQ-036 FFT_LEN=8, one frame with real=3, imag=-4 on all bins -> 8 pwr beats of 25, bins 0..7, latency 2, frame_done, peak_bin=1.
REQ-037 FFT_LEN=8, bin 3 = (-2048, -2048) with DW=12, others 0 -> pwr at bin 3 = 8388608, peak_bin=3, peak_pwr=8388608.
REQ-038 FFT_LEN=8, eop on beat 5 -> err_frame=1, no frame_done, FSM to IDLE; clr_err -> err_frame=0.
REQ-039 Beat without sop in IDLE -> no pwr_valid, err_frame=1; then a good frame -> normal frame_done.
REQ-040 src_error=2'b01 on bin 4 -> err_core=1, frame still completes with frame_done.
REQ-041 rst_n low at bin 4 -> outputs 0, src_ready=1; next full frame -> correct pwr and peak.
